// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin (or fixed CPU priority when DMEM_ARB_CPU_PRIORITY_EN is defined) sharing of one data memory between CPU and host ports
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [31:0]       cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              cpu_rsp_err,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_we,
  input  logic [31:0]       host_req_addr,
  input  logic [DATA_W-1:0] host_req_wdata,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rsp_rdata,
  output logic              host_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic last_grant;
  logic cpu_win, host_win, acc, hit, err, sel_we, rsp_live;
  logic [31:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rsp_data;
  logic rsp_pend, rsp_owner, rsp_isread, rsp_err_q;
`ifdef DMEM_ARB_CPU_PRIORITY_EN
  assign cpu_win  = cpu_req_valid;
  assign host_win = host_req_valid && !cpu_req_valid;
`else
  // last_grant high means the host won last, so the CPU wins a tie
  assign cpu_win  = cpu_req_valid && (!host_req_valid || last_grant);
  assign host_win = host_req_valid && (!cpu_req_valid || !last_grant);
`endif
  assign cpu_req_ready  = cpu_win && !reset;
  assign host_req_ready = host_win && !reset;
  assign acc       = cpu_req_ready || host_req_ready;
  assign sel_we    = host_req_ready ? host_req_we : cpu_req_we;
  assign sel_addr  = host_req_ready ? host_req_addr : cpu_req_addr;
  assign sel_wdata = host_req_ready ? host_req_wdata : cpu_req_wdata;
  assign err       = (|sel_addr[1:0]) || (|sel_addr[31:ADDR_W+2]);
  assign hit       = acc && !err;
  assign mem_en    = hit;
  assign mem_we    = hit && sel_we;
  assign mem_addr  = hit ? sel_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = hit ? sel_wdata : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rsp_pend   <= 1'b0;
      rsp_owner  <= 1'b0;
      rsp_isread <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_pend   <= acc;
      rsp_owner  <= host_req_ready;
      rsp_isread <= !sel_we;
      rsp_err_q  <= err;
      if (acc) last_grant <= host_req_ready;
    end
  end
  // a response pending across an asserted reset is dropped
  assign rsp_live       = rsp_pend && !reset;
  assign rsp_data       = (rsp_isread && !rsp_err_q) ? mem_rdata : '0;
  assign cpu_rsp_valid  = rsp_live && !rsp_owner;
  assign cpu_rsp_err    = cpu_rsp_valid && rsp_err_q;
  assign cpu_rsp_rdata  = cpu_rsp_valid ? rsp_data : '0;
  assign host_rsp_valid = rsp_live && rsp_owner;
  assign host_rsp_err   = host_rsp_valid && rsp_err_q;
  assign host_rsp_rdata = host_rsp_valid ? rsp_data : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a response scoreboard for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_rsp_valid, cpu_rsp_err;
  logic [31:0] cpu_req_addr, cpu_req_wdata, cpu_rsp_rdata;
  logic host_req_valid, host_req_ready, host_req_we, host_rsp_valid, host_rsp_err;
  logic [31:0] host_req_addr, host_req_wdata, host_rsp_rdata;
  logic mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem_arr [32];
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {bit host; bit err; logic [31:0] rdata; int due;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_we(host_req_we),
    .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
    .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata), .host_rsp_err(host_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // synchronous memory, preloaded with 0x1000_0000 + word index while reset is high
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= 32'h1000_0000 + i;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // response monitor: every entry must appear exactly in its due cycle, nothing else may appear
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk(e.host ? "host_rsp_valid" : "cpu_rsp_valid", e.host ? host_rsp_valid : cpu_rsp_valid, 1);
      chk("other_rsp_valid", e.host ? cpu_rsp_valid : host_rsp_valid, 0);
      chk("rsp_err", e.host ? host_rsp_err : cpu_rsp_err, e.err);
      chk("rsp_rdata", e.host ? host_rsp_rdata : cpu_rsp_rdata, e.rdata);
    end else if (cpu_rsp_valid || host_rsp_valid) begin
      chk("unexpected_rsp", {cpu_rsp_valid, host_rsp_valid}, 0);
    end
  end

  task automatic push(input bit host, input bit err, input logic [31:0] rdata);
    exp_t x;
    x.host = host; x.err = err; x.rdata = rdata; x.due = cyc + 1;
    q.push_back(x);
  endtask

  // issue one request; caller is just after a rising edge
  task automatic issue(input bit host, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit exp_err, input logic [31:0] exp_rdata, input bit exp_rsp);
    bit done = 0;
    if (host) begin
      host_req_valid = 1; host_req_we = we; host_req_addr = addr; host_req_wdata = wdata;
    end else begin
      cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
    end
    for (int n = 0; n < 10 && !done; n++) begin
      @(negedge clk);
      if (host ? host_req_ready : cpu_req_ready) begin
        done = 1;
        chk("other_ready", host ? cpu_req_ready : host_req_ready, 0);
        chk("mem_en", mem_en, !exp_err);
        chk("mem_we", mem_we, we && !exp_err);
        chk("mem_addr", mem_addr, exp_err ? 5'd0 : addr[6:2]);
        chk("mem_wdata", mem_wdata, exp_err ? 32'd0 : wdata);
        if (exp_rsp) push(host, exp_err, exp_rdata);
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cpu_req_valid = 0; host_req_valid = 0;
  endtask

  initial begin
    reset = 1;
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 32'h0; cpu_req_wdata = 0;
    host_req_valid = 1; host_req_we = 0; host_req_addr = 32'h4; host_req_wdata = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_cpu_ready", cpu_req_ready, 0);
      chk("rst_host_ready", host_req_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
    end
    @(posedge clk); #1;
    reset = 0;
    // contention with both requests held for six cycles, CPU wins the first tie
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef DMEM_ARB_CPU_PRIORITY_EN
      chk("cont_cpu_ready", cpu_req_ready, 1);
      chk("cont_host_ready", host_req_ready, 0);
      push(0, 0, 32'h1000_0000);
`else
      chk("cont_cpu_ready", cpu_req_ready, (i % 2) == 0);
      chk("cont_host_ready", host_req_ready, (i % 2) == 1);
      if (i % 2 == 0) push(0, 0, 32'h1000_0000);
      else push(1, 0, 32'h1000_0001);
`endif
      @(posedge clk); #1;
    end
    cpu_req_valid = 0; host_req_valid = 0;
    @(negedge clk);
    chk("idle_ready", {cpu_req_ready, host_req_ready}, 0);
    chk("idle_mem_en", mem_en, 0);
    @(posedge clk); #1;
    // host write then back-to-back CPU read of the same word
    issue(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 1);
    issue(0, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1);
    // misaligned CPU read, out-of-range host write, then confirm word 0 untouched
    issue(0, 0, 32'h13, 32'h0, 1, 32'h0, 1);
    issue(1, 1, 32'h80, 32'h1234_5678, 1, 32'h0, 1);
    issue(0, 0, 32'h0, 32'h0, 0, 32'h1000_0000, 1);
    // back-to-back routing to different owners
    issue(0, 0, 32'h4, 32'h0, 0, 32'h1000_0001, 1);
    issue(1, 0, 32'h8, 32'h0, 0, 32'h1000_0002, 1);
    @(posedge clk); #1;
    // reset in the cycle after an accept drops the response
    issue(0, 0, 32'h4, 32'h0, 0, 32'h0, 0);
    reset = 1;
    @(negedge clk);
    chk("midrst_cpu_rsp_valid", cpu_rsp_valid, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midrst_rsp_pend", dut.rsp_pend, 0);
    chk("midrst_cpu_rsp_after", cpu_rsp_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
